// File: rtl/logpix_pkg.sv
// Shared constants and helpers for the log-power pixel pipeline.
package logpix_pkg;

   localparam int LOG_FRAC_BITS = 3;                // 1/8-octave resolution
   localparam int PIX_W         = 8;
   localparam int LATENCY       = 5;                // i_ce -> o_valid, in cycles
   localparam int PIX_MAX       = (1 << PIX_W) - 1;

   // Clamp a signed log difference into the pixel range.
   function automatic logic [PIX_W-1:0] saturate(input int v);
      if (v < 0)
         return '0;
      else if (v > PIX_MAX)
         return PIX_W'(PIX_MAX);
      else
         return PIX_W'(v);
   endfunction

endpackage

// File: rtl/fft_log2.sv
// Combinational log2 approximation: leading-one position plus the
// LOG_FRAC_BITS bits directly below it (zero-padded for small inputs).
module fft_log2 import logpix_pkg::*; #(
   parameter  int PW   = 33,
   localparam int POSW = $clog2(PW),
   localparam int LW   = POSW + LOG_FRAC_BITS
) (
   input  logic [PW-1:0] p,
   output logic [LW-1:0] l,
   output logic          zflag
);

   logic [POSW-1:0]          pos;
   logic [LOG_FRAC_BITS-1:0] frac;

   // Leading-one detect, then pick the bits under it. Appending zeros below
   // p makes the pos < LOG_FRAC_BITS case pad naturally.
   always_comb begin
      pos = '0;
      for (int k = 0; k < PW; k++)
         if (p[k]) pos = POSW'(k);
      frac  = LOG_FRAC_BITS'({p, {LOG_FRAC_BITS{1'b0}}} >> pos);
      l     = {pos, frac};
      zflag = (p == '0);
   end

endmodule

// File: rtl/fft_logpix.sv
// Complex FFT bin -> 8-bit log-power pixel, 5-stage non-stalling pipeline.
// Optional row peak tracker is built when LOGPIX_PEAK_EN is defined;
// otherwise o_peak is tied to zero.
module fft_logpix import logpix_pkg::*; #(
   parameter  int IW         = 16,
   parameter  int OFFSET_RST = 0,
   localparam int PW         = 2*IW + 1,
   localparam int LW         = $clog2(PW) + LOG_FRAC_BITS
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ce,
   input  logic [2*IW-1:0]   i_sample,
   input  logic              i_last,
   input  logic [LW-1:0]     i_offset,
   output logic              o_valid,
   output logic [PIX_W-1:0]  o_pixel,
   output logic              o_last,
   output logic [PIX_W-1:0]  o_peak
);

   logic [LATENCY:1]        vld_pipe, last_pipe;
   logic signed [IW-1:0]    s1_i, s1_q;
   logic signed [2*IW-1:0]  sq_i, sq_q;
   logic [2*IW-1:0]         s2_ii, s2_qq;
   logic [PW-1:0]           s3_p;
   logic [LW-1:0]           log_l, s4_l;
   logic                    log_z, s4_z;
   logic [LW-1:0]           r_offset, eff_off;

   assign o_valid = vld_pipe[LATENCY];
   assign o_last  = last_pipe[LATENCY];
   assign sq_i    = s1_i * s1_i;
   assign sq_q    = s1_q * s1_q;

   // Valid/last shift register; the only control state in the datapath.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[LATENCY-1:1], i_ce};
         last_pipe <= {last_pipe[LATENCY-1:1], i_ce & i_last};
      end
   end

   // Stage data registers S1..S4, enabled by their stage valid, no reset.
   always_ff @(posedge i_clk) begin
      if (i_ce) begin
         s1_i <= i_sample[2*IW-1:IW];
         s1_q <= i_sample[IW-1:0];
      end
      if (vld_pipe[1]) begin
         s2_ii <= sq_i;
         s2_qq <= sq_q;
      end
      if (vld_pipe[2])
         s3_p <= {1'b0, s2_ii} + {1'b0, s2_qq};
      if (vld_pipe[3]) begin
         s4_l <= log_l;
         s4_z <= log_z;
      end
   end

   fft_log2 #(.PW(PW)) u_log2 (
      .p     (s3_p),
      .l     (log_l),
      .zflag (log_z)
   );

   // A new offset applies from the bin right after a row end, so bypass the
   // register on that one cycle; a row never mixes two offsets.
   always_comb eff_off = (o_valid && o_last) ? i_offset : r_offset;

   // S5: offset subtract + saturate, and row-synchronous offset load.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_pixel  <= '0;
         r_offset <= LW'(OFFSET_RST);
      end else begin
         if (o_valid && o_last)
            r_offset <= i_offset;
         if (vld_pipe[LATENCY-1])
            o_pixel <= s4_z ? '0 : saturate(int'(s4_l) - int'(eff_off));
      end
   end

`ifdef LOGPIX_PEAK_EN
   logic [PIX_W-1:0] run_max, row_max;

   assign row_max = (o_pixel > run_max) ? o_pixel : run_max;

   // Running row maximum; published and cleared on the row's final pixel.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         run_max <= '0;
         o_peak  <= '0;
      end else if (o_valid) begin
         if (o_last) begin
            o_peak  <= row_max;
            run_max <= '0;
         end else begin
            run_max <= row_max;
         end
      end
   end
`else
   assign o_peak = '0;
`endif

endmodule

// File: tb/tb_fft_logpix.sv
// Self-checking bench for fft_logpix: directed spec vectors plus randomized
// traffic checked against a plain-arithmetic log-power model.
module tb_fft_logpix;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b0;
   logic [31:0] sample = '0;
   logic        last = 1'b0;
   logic [8:0]  offset = '0;
   logic        ovalid, olast;
   logic [7:0]  opix, opeak;

   fft_logpix #(.IW(16), .OFFSET_RST(0)) dut (
      .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sample(sample), .i_last(last),
      .i_offset(offset), .o_valid(ovalid), .o_pixel(opix), .o_last(olast),
      .o_peak(opeak)
   );

   always #5 clk = ~clk;

   typedef struct {logic [15:0] i; logic [15:0] q; logic last;} bin_t;
   typedef struct {logic [7:0] pix; logic last; int off; int cyc;} cap_t;

   bin_t sentq[$];
   cap_t capq[$];
   int   nchk = 0, nfail = 0, mdl_off = 0, cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output pixel together with the offset presented that cycle.
   always @(negedge clk)
      if (ovalid === 1'b1) capq.push_back('{opix, olast, int'(offset), cyc});

   // Power -> log2 in eighths of an octave, minus offset, clamped to 0..255.
   function automatic int exp_pix(bin_t b, int off);
      longint si, sq, p;
      int pos, l, d;
      si = longint'($signed(b.i));
      sq = longint'($signed(b.q));
      p  = si*si + sq*sq;
      if (p == 0) return 0;
      pos = 0;
      while ((p >> (pos + 1)) != 0) pos++;
      l = 8*pos + int'((p * 8) >> pos) - 8;
      d = l - off;
      if (d < 0) return 0;
      if (d > 255) return 255;
      return d;
   endfunction

   task automatic send_bin(input logic [15:0] i, input logic [15:0] q, input logic l);
      @(posedge clk); #1;
      ce = 1'b1; sample = {i, q}; last = l;
      sentq.push_back('{i, q, l});
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; ce = 1'b0; last = 1'b0; end
   endtask

   task automatic wait_caps();
      int b = 0;
      idle(1);
      while (capq.size() < sentq.size() && b < 400) begin @(posedge clk); b++; end
      idle(3);
   endtask

   task automatic do_reset();
      #1 rst = 1'b1; ce = 1'b0; last = 1'b0;
      repeat (3) @(posedge clk);
      sentq.delete(); capq.delete(); mdl_off = 0;
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      nchk++; if (ovalid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", ovalid); end
      nchk++; if (opix !== 8'h00) begin nfail++; $display("FAIL reset_pixel: got %h want 00", opix); end
      nchk++; if (olast !== 1'b0) begin nfail++; $display("FAIL reset_last: got %b want 0", olast); end
      nchk++; if (opeak !== 8'h00) begin nfail++; $display("FAIL reset_peak: got %h want 00", opeak); end
      do_reset();
   endtask

   task automatic test_latency();
      int n;
      offset = 9'd0;
      send_bin(16'h0100, 16'h0000, 1'b1);
      @(posedge clk); #1; ce = 1'b0; last = 1'b0; n = 1;
      while (ovalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      nchk++; if (n != 5) begin nfail++; $display("FAIL latency: got %0d cycles want 5", n); end
      wait_caps();
      nchk++;
      if (capq.size() != 1 || capq[0].pix !== 8'h80 || capq[0].last !== 1'b1) begin
         nfail++; $display("FAIL latency_pixel: got %0d outputs, want one 80 with last", capq.size());
      end
      mdl_off = 0; sentq.delete(); capq.delete();
   endtask

   task automatic test_directed();
      logic [7:0] ep[5];
      logic       el[5];
      cap_t c;
      ep = '{8'h80, 8'h19, 8'h00, 8'hF8, 8'h30};
      el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      offset = 9'd200;                       // loaded at the end of the first row
      send_bin(16'h0100, 16'h0000, 1'b0);
      send_bin(16'h0003, 16'h0000, 1'b0);
      send_bin(16'h0000, 16'h0000, 1'b0);
      send_bin(16'h8000, 16'h8000, 1'b1);
      wait_caps();
      send_bin(16'h8000, 16'h8000, 1'b1);
      wait_caps();
      nchk++; if (capq.size() != 5) begin nfail++; $display("FAIL directed_count: got %0d want 5", capq.size()); end
      for (int k = 0; k < 5 && capq.size() > 0; k++) begin
         c = capq.pop_front();
         nchk++;
         if (c.pix !== ep[k] || c.last !== el[k]) begin
            nfail++; $display("FAIL directed bin %0d: got %h/%b want %h/%b", k, c.pix, c.last, ep[k], el[k]);
         end
      end
      mdl_off = 200; sentq.delete(); capq.delete();
   endtask

   task automatic test_offset_midrow();
      cap_t c;
      logic [7:0] e;
      offset = 9'd0;
      send_bin(16'h0100, 16'h0000, 1'b1);    // old offset 200 -> 0, loads 0
      wait_caps();
      for (int k = 0; k < 8; k++) begin
         send_bin(16'h0100, 16'h0000, k == 7);
         if (k == 2) offset = 9'd100;
      end
      for (int k = 0; k < 4; k++) send_bin(16'h0100, 16'h0000, k == 3);
      wait_caps();
      nchk++; if (capq.size() != 13) begin nfail++; $display("FAIL offset_count: got %0d want 13", capq.size()); end
      for (int k = 0; k < 13 && capq.size() > 0; k++) begin
         c = capq.pop_front();
         e = (k == 0) ? 8'h00 : (k <= 8) ? 8'h80 : 8'h1C;
         nchk++;
         if (c.pix !== e) begin nfail++; $display("FAIL offset bin %0d: got %h want %h", k, c.pix, e); end
      end
      mdl_off = 100; sentq.delete(); capq.delete();
   endtask

   function automatic logic [15:0] rnd_comp();
      int r = $urandom_range(0, 7);
      if (r == 0) return 16'h8000;
      if (r <= 2) return 16'($urandom_range(0, 15));
      return 16'($urandom);
   endfunction

   task automatic test_random();
      cap_t c; bin_t b; int e, nsent;
      nsent = 300;
      for (int k = 0; k < nsent; k++) begin
         if ($urandom_range(0, 15) == 0) offset = 9'($urandom_range(0, 300));
         send_bin(rnd_comp(), rnd_comp(), (k == nsent-1) || ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      wait_caps();
      nchk++; if (capq.size() != sentq.size()) begin nfail++; $display("FAIL random_count: got %0d want %0d", capq.size(), sentq.size()); end
      for (int k = 0; capq.size() > 0 && sentq.size() > 0; k++) begin
         c = capq.pop_front(); b = sentq.pop_front(); e = exp_pix(b, mdl_off);
         nchk++;
         if (c.pix !== 8'(e) || c.last !== b.last) begin
            nfail++; $display("FAIL random bin %0d: got %h/%b want %h/%b", k, c.pix, c.last, 8'(e), b.last);
         end
         if (c.last) mdl_off = c.off;
      end
      sentq.delete(); capq.delete();
   endtask

   task automatic test_back_to_back();
      cap_t c; bin_t b; int e, nlast, ngap, prev, bad;
      for (int k = 0; k < 1024; k++) send_bin(rnd_comp(), rnd_comp(), k == 1023);
      wait_caps();
      nchk++; if (capq.size() != 1024) begin nfail++; $display("FAIL b2b_count: got %0d want 1024", capq.size()); end
      nlast = 0; ngap = 0; bad = 0; prev = -1;
      for (int k = 0; capq.size() > 0 && sentq.size() > 0; k++) begin
         c = capq.pop_front(); b = sentq.pop_front(); e = exp_pix(b, mdl_off);
         if (prev >= 0 && c.cyc != prev + 1) ngap++;
         prev = c.cyc;
         if (c.last) begin nlast++; if (k != 1023) bad++; end
         nchk++;
         if (c.pix !== 8'(e)) begin nfail++; $display("FAIL b2b bin %0d: got %h want %h", k, c.pix, 8'(e)); end
         if (c.last) mdl_off = c.off;
      end
      nchk++; if (nlast != 1 || bad != 0) begin nfail++; $display("FAIL b2b_last: got %0d lasts (%0d misplaced) want 1", nlast, bad); end
      nchk++; if (ngap != 0) begin nfail++; $display("FAIL b2b_gaps: got %0d gaps want 0", ngap); end
      sentq.delete(); capq.delete();
   endtask

   task automatic test_reset_midrow();
      cap_t c;
      for (int k = 0; k < 500; k++) send_bin(rnd_comp(), rnd_comp(), 1'b0);
      #2 rst = 1'b1; ce = 1'b0;
      #1;
      nchk++; if (ovalid !== 1'b0 || opix !== 8'h00 || olast !== 1'b0) begin
         nfail++; $display("FAIL midrow_reset: got valid %b pixel %h last %b want 0/00/0", ovalid, opix, olast);
      end
      repeat (2) @(posedge clk);
      sentq.delete(); capq.delete(); mdl_off = 0;
      #1 rst = 1'b0; offset = 9'd0;
      idle(12);
      nchk++; if (capq.size() != 0) begin nfail++; $display("FAIL midrow_flush: got %0d outputs after reset want 0", capq.size()); end
      capq.delete();
      send_bin(16'h0100, 16'h0000, 1'b1);
      wait_caps();
      nchk++;
      if (capq.size() != 1) begin
         nfail++; $display("FAIL post_reset_count: got %0d want 1", capq.size());
      end else begin
         c = capq.pop_front();
         if (c.pix !== 8'h80 || c.last !== 1'b1) begin
            nfail++; $display("FAIL post_reset_bin: got %h/%b want 80/1", c.pix, c.last);
         end
      end
      sentq.delete(); capq.delete();
   endtask

   task automatic test_peak();
      send_bin(16'h0002, 16'h0000, 1'b0);    // 0x10
      send_bin(16'h8000, 16'h8000, 1'b0);    // 0xF8
      send_bin(16'h0010, 16'h0000, 1'b1);    // 0x40
      wait_caps();
`ifdef LOGPIX_PEAK_EN
      nchk++; if (opeak !== 8'hF8) begin nfail++; $display("FAIL peak_row1: got %h want F8", opeak); end
`else
      nchk++; if (opeak !== 8'h00) begin nfail++; $display("FAIL peak_off_row1: got %h want 00", opeak); end
`endif
      send_bin(16'h0004, 16'h0000, 1'b0);    // 0x20
      send_bin(16'h0002, 16'h0000, 1'b0);    // 0x10
      send_bin(16'h0001, 16'h0000, 1'b1);    // 0x00
      wait_caps();
`ifdef LOGPIX_PEAK_EN
      nchk++; if (opeak !== 8'h20) begin nfail++; $display("FAIL peak_row2: got %h want 20", opeak); end
`else
      nchk++; if (opeak !== 8'h00) begin nfail++; $display("FAIL peak_off_row2: got %h want 00", opeak); end
`endif
      sentq.delete(); capq.delete();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_offset_midrow();
      test_random();
      test_back_to_back();
      test_reset_midrow();
      test_peak();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
